// File: rtl/arbitro_solicitante.sv
// Requester-side agent for a 4-way priority arbiter: takes a burst job, requests
// the shared resource, streams its beats while granted and releases with an idle gap.
module arbitro_solicitante #(
  parameter int ID      = 0,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic [3:0]       job_len,
  output logic             job_ready,
  output logic             Req,
  input  logic [3:0]       Grant,
  input  logic [1:0]       Grant_num,
  input  logic             Av,
  output logic             bus_en,
  output logic [4:0]       beats_left,
  output logic             done,
  output logic             timeout_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] preempt_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_REL} state_t;

  localparam logic [3:0]       ID_MASK  = 4'(1 << ID);
  localparam logic [1:0]       ID_NUM   = 2'(ID);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             job_ready_q, job_ready_d;
  logic             req_q, req_d;
  logic             bus_en_q, bus_en_d;
  logic [4:0]       beats_q, beats_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             proto_q, proto_d;
  logic [CNT_W-1:0] preempt_q, preempt_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic grant_id;
  logic mine;
  logic grant_bad;

  assign grant_id  = |(Grant & ID_MASK);
  assign mine      = Av & grant_id;
  // Encoded and one-hot grant must agree for this port; a grant without Av is also illegal.
  assign grant_bad = Av ? (grant_id != (Grant_num == ID_NUM)) : grant_id;

  always_comb begin
    state_d     = state_q;
    job_ready_d = job_ready_q;
    req_d       = req_q;
    bus_en_d    = bus_en_q;
    beats_d     = beats_q;
    done_d      = 1'b0;
    tout_d      = 1'b0;
    proto_d     = proto_q | grant_bad;
    preempt_d   = preempt_q;
    wait_d      = wait_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          beats_d     = {1'b0, job_len} + 5'd1;
          wait_d      = '0;
          req_d       = 1'b1;
          job_ready_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (wait_q != CNT_SAT) wait_d = wait_q + CNT_W'(1);
        if (mine) begin
          bus_en_d = 1'b1;
          state_d  = S_OWN;
        end else if (wait_q == WAIT_MAX) begin
          req_d       = 1'b0;
          tout_d      = 1'b1;
          job_ready_d = 1'b1;
          beats_d     = '0;
          state_d     = S_IDLE;
        end
      end
      S_OWN: begin
        if (mine) begin
          beats_d = beats_q - 5'd1;
          if (beats_q == 5'd1) begin
            bus_en_d = 1'b0;
            req_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = S_REL;
          end
        end else begin
          // Preempted: the current cycle carries no beat, keep requesting.
          bus_en_d = 1'b0;
          wait_d   = '0;
          if (preempt_q != CNT_SAT) preempt_d = preempt_q + CNT_W'(1);
          state_d  = S_REQ;
        end
      end
      S_REL: begin
        job_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      job_ready_q <= 1'b1;
      req_q       <= 1'b0;
      bus_en_q    <= 1'b0;
      beats_q     <= '0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
      proto_q     <= 1'b0;
      preempt_q   <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      job_ready_q <= job_ready_d;
      req_q       <= req_d;
      bus_en_q    <= bus_en_d;
      beats_q     <= beats_d;
      done_q      <= done_d;
      tout_q      <= tout_d;
      proto_q     <= proto_d;
      preempt_q   <= preempt_d;
      wait_q      <= wait_d;
    end
  end

  assign job_ready   = job_ready_q;
  assign Req         = req_q;
  assign bus_en      = bus_en_q;
  assign beats_left  = beats_q;
  assign done        = done_q;
  assign timeout_err = tout_q;
  assign proto_err   = proto_q;
  assign preempt_cnt = preempt_q;

endmodule
